// File: rtl/axis_hdr_pkg.sv
// Types and keep-vector helpers shared by the header insert/strip stream blocks.
// Helpers work on a wide keep vector; callers zero-extend or slice to their own width.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } hdr_state_e;

  localparam int unsigned KEEP_MAX_W = 64;

  // cnt ones packed against the MSB of a width-bit keep vector
  function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int unsigned cnt,
                                                      input int unsigned width);
    logic [KEEP_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
      if ((i < width) && (i + cnt >= width)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int unsigned keep_cnt(input logic [KEEP_MAX_W-1:0] keep);
    int unsigned c;
    c = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (keep[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_byte_funnel.sv
// Merges R held bytes with an incoming beat: output word is the held bytes followed by the
// beat's leading bytes, and the beat's trailing R bytes become the new MSB-aligned hold.
module axis_byte_funnel #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]     hold_i,
  input  logic [DATA_WD-1:0]     beat_i,
  input  logic [BYTE_CNT_WD-1:0] rcnt_i,
  output logic [DATA_WD-1:0]     word_o,
  output logic [DATA_WD-1:0]     hold_o
);

  localparam int unsigned BW = DATA_BYTE_WD;

  int unsigned sh_lo;
  int unsigned sh_hi;

  // hold_i lanes past R are zero, so OR-ing in the right-shifted beat is a clean merge.
  // A shift of the full word width yields zero, which covers R=0 and R=W.
  always_comb begin
    sh_lo  = 32'(rcnt_i) * 8;
    sh_hi  = (BW - 32'(rcnt_i)) * 8;
    word_o = hold_i | (beat_i >> sh_lo);
    hold_o = beat_i << sh_hi;
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet H-byte header off an AXI-Stream packet onto a separate header channel
// and re-aligns the remaining payload to byte 0 of the output stream.
module axi_stream_strip_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic                    err_short
);

  localparam int unsigned W = DATA_BYTE_WD;

  function automatic logic [DATA_BYTE_WD-1:0] kmask(input int unsigned cnt);
    logic [KEEP_MAX_W-1:0] m;
    m = keep_mask(cnt, W);
    return m[DATA_BYTE_WD-1:0];
  endfunction

  function automatic int unsigned kcnt(input logic [DATA_BYTE_WD-1:0] k);
    return keep_cnt(KEEP_MAX_W'(k));
  endfunction

  function automatic logic [DATA_WD-1:0] lanes(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int b = 0; b < DATA_BYTE_WD; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  hdr_state_e              state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  rcnt_q, rcnt_d;
  logic [DATA_WD-1:0]      hold_q, hold_d;
  logic                    init_q;
  logic                    ovld_q, ovld_d;
  logic                    olast_q, olast_d;
  logic [DATA_WD-1:0]      odata_q, odata_d;
  logic [DATA_BYTE_WD-1:0] okeep_q, okeep_d;
  logic                    hvld_q, hvld_d;
  logic [DATA_WD-1:0]      hdata_q, hdata_d;
  logic [DATA_BYTE_WD-1:0] hkeep_q, hkeep_d;
  logic                    err_q, err_d;

  logic [DATA_WD-1:0]      f_word;
  logic [DATA_WD-1:0]      f_hold;
  logic                    out_free;
  logic                    acc;
  int unsigned             h_cnt, n_cnt, r_cnt, hc, room;

  axis_byte_funnel #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_funnel (
    .hold_i (hold_q),
    .beat_i (data_in),
    .rcnt_i (rcnt_q),
    .word_o (f_word),
    .hold_o (f_hold)
  );

  // init_q keeps ready_in low through reset and raises it on the first post-reset edge
  assign out_free = !ovld_q || ready_out;
  assign ready_in = init_q && out_free && (state_q != FLUSH) &&
                    ((state_q != HEAD) || !hvld_q || ready_header);
  assign acc      = valid_in && ready_in;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    hold_d  = hold_q;
    ovld_d  = ovld_q && !ready_out;
    olast_d = olast_q;
    odata_d = odata_q;
    okeep_d = okeep_q;
    hvld_d  = hvld_q && !ready_header;
    hdata_d = hdata_q;
    hkeep_d = hkeep_q;
    err_d   = 1'b0;

    h_cnt = (32'(byte_strip_cnt) > W) ? W : 32'(byte_strip_cnt);
    n_cnt = last_in ? kcnt(keep_in) : W;
    r_cnt = 32'(rcnt_q);
    hc    = (n_cnt < h_cnt) ? n_cnt : h_cnt;
    room  = W - r_cnt;

    unique case (state_q)
      HEAD: begin
        if (acc) begin
          hvld_d  = 1'b1;
          hkeep_d = kmask(hc);
          hdata_d = data_in & lanes(kmask(hc));
          rcnt_d  = BYTE_CNT_WD'(W - h_cnt);
          hold_d  = data_in << (8 * h_cnt);
          if (!last_in) begin
            state_d = BODY;
          end else begin
            // single-beat packet: whatever follows the header leaves immediately
            rcnt_d = '0;
            hold_d = '0;
            err_d  = (n_cnt < h_cnt);
            if (n_cnt > h_cnt) begin
              ovld_d  = 1'b1;
              olast_d = 1'b1;
              okeep_d = kmask(n_cnt - h_cnt);
              odata_d = (data_in << (8 * h_cnt)) & lanes(kmask(n_cnt - h_cnt));
            end
          end
        end
      end
      BODY: begin
        if (acc) begin
          ovld_d  = 1'b1;
          olast_d = 1'b0;
          okeep_d = '1;
          odata_d = f_word;
          hold_d  = f_hold;
          if (last_in) begin
            if (n_cnt <= room) begin
              olast_d = 1'b1;
              okeep_d = kmask(r_cnt + n_cnt);
              odata_d = f_word & lanes(kmask(r_cnt + n_cnt));
              state_d = HEAD;
              rcnt_d  = '0;
              hold_d  = '0;
            end else begin
              // tail spills past this word; rcnt now counts the bytes left to flush
              hold_d  = f_hold & lanes(kmask(n_cnt - room));
              rcnt_d  = BYTE_CNT_WD'(n_cnt - room);
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ovld_d  = 1'b1;
          olast_d = 1'b1;
          okeep_d = kmask(r_cnt);
          odata_d = hold_q;
          state_d = HEAD;
          rcnt_d  = '0;
          hold_d  = '0;
        end
      end
      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEAD;
      rcnt_q  <= '0;
      hold_q  <= '0;
      init_q  <= 1'b0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
      okeep_q <= '0;
      hvld_q  <= 1'b0;
      hdata_q <= '0;
      hkeep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      hold_q  <= hold_d;
      init_q  <= 1'b1;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
      odata_q <= odata_d;
      okeep_q <= okeep_d;
      hvld_q  <= hvld_d;
      hdata_q <= hdata_d;
      hkeep_q <= hkeep_d;
      err_q   <= err_d;
    end
  end

  assign valid_out    = ovld_q;
  assign data_out     = odata_q;
  assign keep_out     = okeep_q;
  assign last_out     = olast_q;
  assign valid_header = hvld_q;
  assign data_header  = hdata_q;
  assign keep_header  = hkeep_q;
  assign err_short    = err_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header at W=4: byte-queue packet model plus literal pins.
module tb_axi_stream_strip_header;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 3;

  typedef struct packed { logic [DW-1:0] d; logic [BW-1:0] k; logic l; } beat_t;
  typedef struct packed { logic [DW-1:0] d; logic [BW-1:0] k; } hdr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [BW-1:0] keep_in;
  logic          last_in;
  logic [CW-1:0] byte_strip_cnt;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_header;
  logic [DW-1:0] data_header;
  logic [BW-1:0] keep_header;
  logic          ready_header;
  logic          err_short;

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .byte_strip_cnt(byte_strip_cnt), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .ready_header(ready_header), .err_short(err_short)
  );

  int    tests = 0;
  int    fails = 0;
  beat_t exp_pl[$];
  beat_t got_pl[$];
  hdr_t  exp_hd[$];
  hdr_t  got_hd[$];
  int    exp_err = 0;
  int    got_err = 0;
  logic  chk_en = 1'b0;
  logic  ro_toggle = 1'b0;
  logic [DW-1:0] sd [8];
  logic [BW-1:0] sk [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Packet model: header = first min(H, bytes of first beat) bytes; payload = every later byte,
  // repacked into W-byte beats with last on the final one.
  task automatic model_pkt(input int h, input int nb);
    logic [7:0] bq[$];
    int hh, n0, hc;
    hdr_t  eh;
    beat_t b;
    hh = (h > BW) ? BW : h;
    n0 = 0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < BW; j++)
        if (sk[i][BW-1-j]) begin
          bq.push_back(sd[i][DW-1-8*j -: 8]);
          if (i == 0) n0++;
        end
    hc = (n0 < hh) ? n0 : hh;
    eh = '0;
    for (int j = 0; j < hc; j++) begin
      eh.d[DW-1-8*j -: 8] = bq.pop_front();
      eh.k[BW-1-j] = 1'b1;
    end
    exp_hd.push_back(eh);
    if (hc < hh) exp_err++;
    while (bq.size() > 0) begin
      b = '0;
      for (int j = 0; j < BW; j++)
        if (bq.size() > 0) begin
          b.d[DW-1-8*j -: 8] = bq.pop_front();
          b.k[BW-1-j] = 1'b1;
        end
      b.l = (bq.size() == 0);
      exp_pl.push_back(b);
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l, input int h);
    int   waitc;
    logic acc;
    waitc = 0;
    acc = 1'b0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_strip_cnt = CW'(h);
    while (!acc) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      waitc++;
      if (!acc && waitc > 200) begin
        tests++; fails++;
        $display("FAIL ready_in_timeout: got no accept after %0d cycles expected accept", waitc);
        acc = 1'b1;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic send_pkt(input int h, input int nb);
    model_pkt(h, nb);
    for (int i = 0; i < nb; i++) drive(sd[i], sk[i], (i == nb - 1), h);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_pl.size() != 0 || exp_hd.size() != 0) && c < 100) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (exp_pl.size() != 0 || exp_hd.size() != 0) begin
      fails++;
      $display("FAIL drain: pending payload %0d header %0d expected 0 0", exp_pl.size(), exp_hd.size());
    end
  endtask

  // Compare process: every accepted payload/header beat against the model, in order
  initial forever begin
    beat_t eb;
    hdr_t  eh;
    @(negedge clk);
    if (!rst && chk_en) begin
      if (valid_out && ready_out) begin
        got_pl.push_back({data_out, keep_out, last_out});
        if (exp_pl.size() == 0) begin
          tests++; fails++;
          $display("FAIL payload_extra: got %0h/%0h/%0b expected none", data_out, keep_out, last_out);
        end else begin
          eb = exp_pl.pop_front();
          chk("payload_data", data_out, eb.d);
          chk("payload_keep", keep_out, eb.k);
          chk("payload_last", last_out, eb.l);
        end
      end
      if (valid_header && ready_header) begin
        got_hd.push_back({data_header, keep_header});
        if (exp_hd.size() == 0) begin
          tests++; fails++;
          $display("FAIL header_extra: got %0h/%0h expected none", data_header, keep_header);
        end else begin
          eh = exp_hd.pop_front();
          chk("header_data", data_header, eh.d);
          chk("header_keep", keep_header, eh.k);
        end
      end
      if (err_short) got_err++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ro_toggle) ready_out = ~ready_out;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, g0, e0;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    byte_strip_cnt = '0; ready_out = 1'b1; ready_header = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_valid_header", valid_header, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_data_out", {data_out, keep_out}, 0);
    chk("rst_data_header", {data_header, keep_header}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_in_after_rst", ready_in, 1);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // 1: H=2, two full beats -> FLUSH path
    b0 = got_pl.size(); g0 = got_hd.size();
    sd[0] = 32'hA1A2A3A4; sk[0] = 4'hF; sd[1] = 32'hB1B2B3B4; sk[1] = 4'hF;
    send_pkt(2, 2);
    drain();
    chk("t1_hdr", got_hd[g0], {32'hA1A20000, 4'hC});
    chk("t1_pl0", got_pl[b0], {32'hA3A4B1B2, 4'hF, 1'b0});
    chk("t1_pl1", got_pl[b0+1], {32'hB3B40000, 4'hC, 1'b1});

    // 2: H=2, short last beat with junk in unused lanes
    b0 = got_pl.size(); g0 = got_hd.size();
    sd[0] = 32'hA1A2A3A4; sk[0] = 4'hF; sd[1] = 32'hB1EEEEEE; sk[1] = 4'h8;
    send_pkt(2, 2);
    drain();
    chk("t2_hdr", got_hd[g0], {32'hA1A20000, 4'hC});
    chk("t2_pl0", got_pl[b0], {32'hA3A4B100, 4'hE, 1'b1});
    chk("t2_count", got_pl.size() - b0, 1);

    // 3: all-header beat, then a packet shorter than its header
    b0 = got_pl.size(); g0 = got_hd.size(); e0 = got_err;
    sd[0] = 32'h11223344; sk[0] = 4'hF;
    send_pkt(4, 1);
    drain();
    chk("t3a_hdr", got_hd[g0], {32'h11223344, 4'hF});
    chk("t3a_no_payload", got_pl.size() - b0, 0);
    chk("t3a_no_err", got_err - e0, 0);
    sd[0] = 32'hAABBCCDD; sk[0] = 4'hC;
    send_pkt(3, 1);
    drain();
    chk("t3b_hdr", got_hd[g0+1], {32'hAABB0000, 4'hC});
    chk("t3b_no_payload", got_pl.size() - b0, 0);
    chk("t3b_err_pulse", got_err - e0, 1);

    // 4: H=0 pass-through with ready_out toggling
    b0 = got_pl.size(); g0 = got_hd.size();
    sd[0] = 32'h01020304; sk[0] = 4'hF;
    sd[1] = 32'h05060708; sk[1] = 4'hF;
    sd[2] = 32'h090A0B0C; sk[2] = 4'hF;
    ro_toggle = 1'b1;
    send_pkt(0, 3);
    drain();
    ro_toggle = 1'b0; ready_out = 1'b1;
    chk("t4_hdr", got_hd[g0], 36'h0);
    chk("t4_pl0", got_pl[b0], {32'h01020304, 4'hF, 1'b0});
    chk("t4_pl2", got_pl[b0+2], {32'h090A0B0C, 4'hF, 1'b1});
    chk("t4_count", got_pl.size() - b0, 3);

    // 5: stalled header channel blocks the next packet's first beat
    b0 = got_pl.size(); g0 = got_hd.size();
    ready_header = 1'b0;
    sd[0] = 32'h21222324; sk[0] = 4'hF; sd[1] = 32'h25262728; sk[1] = 4'h8;
    send_pkt(1, 2);
    sd[0] = 32'h31323334; sk[0] = 4'hF;
    fork
      send_pkt(3, 1);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t5_blocked_ready_in", ready_in, 0);
          chk("t5_hdr_held", valid_header, 1);
        end
        @(posedge clk); #1;
        ready_header = 1'b1;
      end
    join
    drain();
    chk("t5_hdr0", got_hd[g0], {32'h21000000, 4'h8});
    chk("t5_hdr1", got_hd[g0+1], {32'h31323300, 4'hE});
    chk("t5_pl0", got_pl[b0], {32'h22232425, 4'hF, 1'b1});
    chk("t5_pl1", got_pl[b0+1], {32'h34000000, 4'h8, 1'b1});

    // 6: reset pulse in the middle of a packet
    chk_en = 1'b0;
    drive(32'hE1E2E3E4, 4'hF, 1'b0, 2);
    drive(32'hE5E6E7E8, 4'hF, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_out", valid_out, 0);
    chk("t6_valid_header", valid_header, 0);
    chk("t6_ready_in_low", ready_in, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_ready_in_high", ready_in, 1);
    chk_en = 1'b1;
    @(posedge clk); #1;
    b0 = got_pl.size(); g0 = got_hd.size();
    sd[0] = 32'hC1C2C3C4; sk[0] = 4'hF; sd[1] = 32'hD1D2D3D4; sk[1] = 4'hF;
    send_pkt(1, 2);
    drain();
    chk("t6_hdr", got_hd[g0], {32'hC1000000, 4'h8});
    chk("t6_pl0", got_pl[b0], {32'hC2C3C4D1, 4'hF, 1'b0});
    chk("t6_pl1", got_pl[b0+1], {32'hD2D3D400, 4'hE, 1'b1});

    repeat (3) @(posedge clk);
    chk("err_count", got_err, exp_err);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
